// File: rtl/rr_pkg.sv
// Shared constants, FSM state type and grant helper for the round-robin requester agent and arbiter.
package rr_pkg;

    localparam int unsigned RR_NUM_PORTS = 4;
    localparam int unsigned RR_LEN_W     = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rr_agent_state_e;

    // True when exactly one bit of vec is set.
    function automatic logic onehot_valid(input logic [31:0] vec);
        return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/rr_len_fifo.sv
// Single-port burst-length FIFO; a push into a full FIFO is dropped even when a pop happens in the same cycle.
module rr_len_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == CW'(0));
    assign full    = (count == CW'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rr_req_agent.sv
// Requester front end for the round-robin arbiter: queues bursts per client, requests, owns the resource per burst.
// Optional sticky drop flag ovf_o is enabled by defining RR_REQ_AGENT_OVF_EN.
module rr_req_agent
    import rr_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = RR_NUM_PORTS,
    parameter int unsigned LEN_W      = RR_LEN_W,
    parameter int unsigned PEND_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_PORTS-1:0]       push_i,
    input  logic [NUM_PORTS*LEN_W-1:0] push_len_i,
    output logic [NUM_PORTS-1:0]       full_o,
    output logic [NUM_PORTS-1:0]       req_o,
    input  logic [NUM_PORTS-1:0]       gnt_i,
    output logic [NUM_PORTS-1:0]       own_o,
    output logic                       beat_valid_o,
    input  logic                       beat_ready_i,
    output logic                       last_o,
    output logic [NUM_PORTS-1:0]       done_o
`ifdef RR_REQ_AGENT_OVF_EN
    ,
    output logic [NUM_PORTS-1:0]       ovf_o
`endif
);

    rr_agent_state_e state_q;
    rr_agent_state_e state_d;

    logic [NUM_PORTS-1:0][LEN_W-1:0] head;
    logic [NUM_PORTS-1:0]            empty;
    logic [NUM_PORTS-1:0]            full;
    logic [NUM_PORTS-1:0]            pop;
    logic [LEN_W-1:0]                head_sel;
    logic                            grant_ok;
    logic [NUM_PORTS-1:0]            own_q;
    logic [LEN_W-1:0]                cnt_q;
    logic [NUM_PORTS-1:0]            done_q;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_fifo
        rr_len_fifo #(
            .WIDTH (LEN_W),
            .DEPTH (PEND_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push_i[p]),
            .pop   (pop[p]),
            .din   (push_len_i[p*LEN_W +: LEN_W]),
            .head  (head[p]),
            .empty (empty[p]),
            .full  (full[p])
        );
    end

    // Outputs decode from registered state only, so req_o never depends on gnt_i.
    assign req_o        = (state_q == IDLE)  ? ~empty : '0;
    assign own_o        = (state_q == BURST) ? own_q  : '0;
    assign beat_valid_o = (state_q == BURST);
    assign last_o       = (state_q == BURST) && (cnt_q == '0);
    assign done_o       = done_q;
    assign full_o       = full;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        pop      = '0;
        grant_ok = 1'b0;
        head_sel = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt_i[p]) head_sel = head_sel | head[p];
        end
        case (state_q)
            IDLE: begin
                grant_ok = onehot_valid(32'(gnt_i)) && ((gnt_i & ~empty) != '0);
                if (grant_ok) begin
                    pop     = gnt_i;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (beat_ready_i && (cnt_q == '0)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Owner latch, beat countdown and completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            own_q  <= '0;
            cnt_q  <= '0;
            done_q <= '0;
        end else begin
            done_q <= '0;
            if (grant_ok) begin
                own_q <= gnt_i;
                cnt_q <= head_sel;
            end else if ((state_q == BURST) && beat_ready_i) begin
                if (cnt_q == '0) begin
                    done_q <= own_q;
                    own_q  <= '0;
                end else begin
                    cnt_q <= cnt_q - LEN_W'(1);
                end
            end
        end
    end

`ifdef RR_REQ_AGENT_OVF_EN
    logic [NUM_PORTS-1:0] ovf_q;

    always_ff @(posedge clk) begin
        if (reset) ovf_q <= '0;
        else       ovf_q <= ovf_q | (push_i & full);
    end

    assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_rr_req_agent.sv
// Bench for rr_req_agent: queue-level reference model checked every cycle, directed scenarios, random traffic.
module tb_rr_req_agent;

    localparam int unsigned NP = 4;
    localparam int unsigned LW = 4;
    localparam int unsigned PD = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     push_i;
    logic [NP*LW-1:0]  push_len_i;
    logic [NP-1:0]     full_o;
    logic [NP-1:0]     req_o;
    logic [NP-1:0]     gnt_i;
    logic [NP-1:0]     own_o;
    logic              beat_valid_o;
    logic              beat_ready_i;
    logic              last_o;
    logic [NP-1:0]     done_o;
`ifdef RR_REQ_AGENT_OVF_EN
    logic [NP-1:0]     ovf_o;
`endif

    logic              force_en;
    logic [NP-1:0]     gnt_force;
    logic [NP-1:0]     arb_gnt;
    int                arb_idx;
    int                rr_ptr;

    int n_cmp = 0;
    int n_bad = 0;

    rr_req_agent #(.NUM_PORTS(NP), .LEN_W(LW), .PEND_DEPTH(PD)) dut (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push_i),
        .push_len_i   (push_len_i),
        .full_o       (full_o),
        .req_o        (req_o),
        .gnt_i        (gnt_i),
        .own_o        (own_o),
        .beat_valid_o (beat_valid_o),
        .beat_ready_i (beat_ready_i),
        .last_o       (last_o),
        .done_o       (done_o)
`ifdef RR_REQ_AGENT_OVF_EN
        ,
        .ovf_o        (ovf_o)
`endif
    );

    always #5 clk = ~clk;

    // Bench-side round-robin arbiter: grant the first requester at or after rr_ptr.
    always_comb begin
        arb_gnt = '0;
        arb_idx = 0;
        for (int k = 0; k < NP; k++) begin
            if (arb_gnt == '0 && req_o[(rr_ptr + k) % NP]) begin
                arb_gnt[(rr_ptr + k) % NP] = 1'b1;
                arb_idx = (rr_ptr + k) % NP;
            end
        end
    end

    always @(posedge clk) begin
        if (reset) rr_ptr <= 0;
        else if (!force_en && arb_gnt != '0) rr_ptr <= (arb_idx + 1) % NP;
    end

    assign gnt_i = force_en ? gnt_force : arb_gnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            mq [NP][$];
    bit            m_busy;
    int            m_own;
    int            m_rem;
    logic [NP-1:0] m_done;
    logic [NP-1:0] m_ovf;
    bit            mdl_live = 1'b0;
    logic [NP-1:0] s_rq, s_fp, s_nd;

    function automatic logic [NP-1:0] exp_req();
        logic [NP-1:0] r = '0;
        if (!m_busy)
            for (int p = 0; p < NP; p++) r[p] = (mq[p].size() != 0);
        return r;
    endfunction

    function automatic logic [NP-1:0] exp_full();
        logic [NP-1:0] f = '0;
        for (int p = 0; p < NP; p++) f[p] = (mq[p].size() == PD);
        return f;
    endfunction

    function automatic int idx_of(input logic [NP-1:0] v);
        for (int i = 0; i < NP; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (mdl_live) begin
            chk("mdl req_o",  32'(req_o),  32'(exp_req()));
            chk("mdl full_o", 32'(full_o), 32'(exp_full()));
            chk("mdl own_o",  32'(own_o),  m_busy ? (32'd1 << m_own) : 32'd0);
            chk("mdl beat_valid_o", 32'(beat_valid_o), 32'(m_busy));
            chk("mdl last_o", 32'(last_o), 32'(m_busy && m_rem == 0));
            chk("mdl done_o", 32'(done_o), 32'(m_done));
`ifdef RR_REQ_AGENT_OVF_EN
            chk("mdl ovf_o",  32'(ovf_o),  32'(m_ovf));
`endif
        end
        if (reset) begin
            for (int p = 0; p < NP; p++) mq[p].delete();
            m_busy = 1'b0; m_own = 0; m_rem = 0; m_done = '0; m_ovf = '0;
            mdl_live = 1'b1;
        end else begin
            s_rq = exp_req();
            s_fp = exp_full();
            s_nd = '0;
            if (m_busy) begin
                if (beat_ready_i) begin
                    if (m_rem == 0) begin
                        m_busy = 1'b0;
                        s_nd[m_own] = 1'b1;
                    end else begin
                        m_rem--;
                    end
                end
            end else if ($countones(gnt_i) == 1 && (gnt_i & s_rq) != '0) begin
                m_own  = idx_of(gnt_i);
                m_rem  = mq[m_own].pop_front();
                m_busy = 1'b1;
            end
            for (int p = 0; p < NP; p++) begin
                if (push_i[p]) begin
                    if (!s_fp[p]) mq[p].push_back(int'(push_len_i[p*LW +: LW]));
                    else          m_ovf[p] = 1'b1;
                end
            end
            m_done = s_nd;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        push_i       = '0;
        push_len_i   = '0;
        beat_ready_i = 1'b1;
        force_en     = 1'b0;
        gnt_force    = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int q_own[$];
    int cnt;
    int beats;
    bit seen;

    initial begin
        quiet();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("reset req_o", 32'(req_o), 32'h0);
        chk("reset own_o", 32'(own_o), 32'h0);
        chk("reset full_o", 32'(full_o), 32'h0);
        chk("reset valid/last/done", {30'(done_o), beat_valid_o, last_o}, 32'h0);

        // Single request on port 2, len 3
        next_cycle();
        push_i = 4'b0100; push_len_i = 16'h0300;
        next_cycle();
        push_i = '0;
        @(negedge clk);
        chk("single req c1", 32'(req_o), 32'h4);
        chk("single own c1", 32'(own_o), 32'h0);
        for (int c = 2; c <= 5; c++) begin
            next_cycle();
            @(negedge clk);
            chk("single own", 32'(own_o), 32'h4);
            chk("single valid", 32'(beat_valid_o), 32'h1);
            chk("single last", 32'(last_o), 32'(c == 5));
        end
        next_cycle();
        @(negedge clk);
        chk("single done c6", 32'(done_o), 32'h4);
        chk("single own c6", 32'(own_o), 32'h0);

        // Round robin: all ports twice, len 0
        do_reset();
        push_i = 4'b1111; push_len_i = '0;
        next_cycle();
        next_cycle();
        push_i = '0;
        q_own.delete();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_o != '0) q_own.push_back(idx_of(done_o));
            if (q_own.size() == 8) break;
            next_cycle();
        end
        chk("rr done count", 32'(q_own.size()), 32'd8);
        for (int i = 0; i < q_own.size(); i++) chk("rr owner order", 32'(q_own[i]), 32'(i % 4));

        // Backpressure: len 1, ready low for 5 cycles on the first beat
        do_reset();
        beat_ready_i = 1'b0;
        push_i = 4'b0001; push_len_i = 16'h0001;
        next_cycle();
        push_i = '0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (beat_valid_o) seen = 1'b1;
            else next_cycle();
        end
        chk("bp first beat seen", 32'(seen), 32'h1);
        chk("bp last while stalled", 32'(last_o), 32'h0);
        for (int k = 1; k < 5; k++) begin
            next_cycle();
            @(negedge clk);
            chk("bp valid held", 32'(beat_valid_o), 32'h1);
            chk("bp last held", 32'(last_o), 32'h0);
        end
        next_cycle();
        beat_ready_i = 1'b1;
        beats = 0; seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (done_o != '0) seen = 1'b1;
            else begin
                if (beat_valid_o && beat_ready_i) beats++;
                next_cycle();
            end
        end
        chk("bp done seen", 32'(seen), 32'h1);
        chk("bp accepted beats", 32'(beats), 32'd2);

        // Full and drop on port 1
        do_reset();
        force_en = 1'b1; gnt_force = '0;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            push_i = 4'b0010; push_len_i = '0;
            @(negedge clk);
            if (i == 3) chk("full after 3 pushes", 32'(full_o), 32'h0);
            if (i == 4) chk("full after 4 pushes", 32'(full_o), 32'h2);
        end
        next_cycle();
        push_i = '0;
        @(negedge clk);
        chk("full after drop", 32'(full_o), 32'h2);
`ifdef RR_REQ_AGENT_OVF_EN
        chk("ovf after drop", 32'(ovf_o), 32'h2);
`endif
        force_en = 1'b0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            next_cycle();
            @(negedge clk);
            if (done_o[1]) cnt++;
        end
        chk("drop burst count", 32'(cnt), 32'd4);
        chk("full drained", 32'(full_o), 32'h0);

        // Bad grants: multi-hot, then one-hot unrequested
        do_reset();
        force_en = 1'b1; gnt_force = '0;
        push_i = 4'b0001; push_len_i = '0;
        next_cycle();
        push_i = '0;
        gnt_force = 4'b0011;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) gnt_force = 4'b1000;
            @(negedge clk);
            chk("badgnt own", 32'(own_o), 32'h0);
            chk("badgnt valid", 32'(beat_valid_o), 32'h0);
            chk("badgnt req kept", 32'(req_o), 32'h1);
            next_cycle();
            if (i == 2) gnt_force = 4'b1000;
        end
        force_en = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done_o[0]) cnt++;
            next_cycle();
        end
        chk("badgnt later burst", 32'(cnt), 32'd1);

        // Reset during the third beat of a len 7 burst, a second entry queued behind it
        do_reset();
        force_en = 1'b1; gnt_force = '0;
        push_i = 4'b1000; push_len_i = 16'h7000;
        next_cycle();
        push_len_i = 16'h2000;
        next_cycle();
        push_i = '0;
        force_en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (beat_valid_o) seen = 1'b1;
            else next_cycle();
        end
        chk("rst burst started", 32'(seen), 32'h1);
        next_cycle();
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("rst third beat valid", 32'(beat_valid_o), 32'h1);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("rst req_o", 32'(req_o), 32'h0);
        chk("rst own_o", 32'(own_o), 32'h0);
        chk("rst valid/last", {30'd0, beat_valid_o, last_o}, 32'h0);
        chk("rst done_o", 32'(done_o), 32'h0);
        chk("rst full_o", 32'(full_o), 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            @(negedge clk);
            if (done_o != '0 || req_o != '0) seen = 1'b1;
        end
        chk("rst no done/req after", 32'(seen), 32'h0);

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            next_cycle();
            reset = ($urandom_range(0, 299) == 0);
            for (int p = 0; p < NP; p++) push_i[p] = ($urandom_range(0, 3) == 0);
            push_len_i   = 16'($urandom);
            beat_ready_i = ($urandom_range(0, 3) != 0);
            force_en     = ($urandom_range(0, 9) == 0);
            gnt_force    = 4'($urandom);
        end
        next_cycle();
        quiet();
        reset = 1'b0;
        repeat (3) next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
